reg_file_8x8: RTL and testbench

// - Register file of the 8-bit single-cycle CPU: 8 registers x 8 bits,
//   two combinational read ports and one clocked write port.
// - OUT1 feeds the ALU DATA1 input.
// - OUT2 feeds the negate / immediate select muxes in front of ALU DATA2.
// - Writeback (ALU result or memory read data) arrives on IN.
// - Per-register valid bits flag registers not written since reset.
//   The test bench and control logic use them to catch reads of

---
 rtl/reg_file_8x8.sv | 73 +++++++
 tb/tb_reg_file_8x8.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_8x8.sv
// Purpose: 8x8 CPU register file, two combinational read ports, one clocked write port, per-register valid bits.
// Latency: reads are zero-cycle; a write is visible on the reads after its committing rising edge.
// Backpressure: BUSYWAIT=1 suppresses the write on that edge; the held write commits once on the first edge with BUSYWAIT=0.
module reg_file_8x8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter bit BYPASS = 1'b0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic              BUSYWAIT,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic              OUT1VALID,
  output logic              OUT2VALID
);

  localparam int DEPTH = 1 << ADDR_W;

  // Register storage and "written since reset" flags.
  logic [DATA_W-1:0] reg_dat [DEPTH];
  logic [DEPTH-1:0]  reg_vld;

  // A write commits only when requested and the memory is not stalling.
  logic wr_commit;
  assign wr_commit = WRITE & ~BUSYWAIT;

  // Bypass hits: only meaningful out of reset and only when enabled, since
  // in the single-cycle CPU a bypass path closes a loop through the ALU.
  logic byp1_hit;
  logic byp2_hit;
  assign byp1_hit = BYPASS && RESET_N && wr_commit && (OUT1ADDRESS == INADDRESS);
  assign byp2_hit = BYPASS && RESET_N && wr_commit && (OUT2ADDRESS == INADDRESS);

  // Storage update: async clear of data and valid flags, single-entry write on commit.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        reg_dat[i] <= '0;
      end
      reg_vld <= '0;
    end else if (wr_commit) begin
      reg_dat[INADDRESS] <= IN;
      reg_vld[INADDRESS] <= 1'b1;
    end
  end

  // Read port 1: stored value, or in-flight write data when bypassing.
  always_comb begin
    OUT1      = reg_dat[OUT1ADDRESS];
    OUT1VALID = reg_vld[OUT1ADDRESS];
    if (byp1_hit) begin
      OUT1      = IN;
      OUT1VALID = 1'b1;
    end
  end

  // Read port 2: same rules as port 1, independent address.
  always_comb begin
    OUT2      = reg_dat[OUT2ADDRESS];
    OUT2VALID = reg_vld[OUT2ADDRESS];
    if (byp2_hit) begin
      OUT2      = IN;
      OUT2VALID = 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file_8x8.sv
// Bench for reg_file_8x8: directed scenarios plus random traffic against an array model.
// Two instances share the stimulus: one without bypass, one with bypass.
// Outputs are sampled between clock edges, never on the active edge.
module tb_reg_file_8x8;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [7:0] IN;
  logic [2:0] INADDRESS;
  logic       WRITE;
  logic       BUSYWAIT;
  logic [2:0] OUT1ADDRESS;
  logic [2:0] OUT2ADDRESS;
  logic [7:0] OUT1, OUT2, b_out1, b_out2;
  logic       OUT1VALID, OUT2VALID, b_out1_vld, b_out2_vld;

  always #10 CLK = ~CLK;

  reg_file_8x8 #(.DATA_W(8), .ADDR_W(3), .BYPASS(1'b0)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .IN(IN), .INADDRESS(INADDRESS),
    .WRITE(WRITE), .BUSYWAIT(BUSYWAIT),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(OUT1), .OUT2(OUT2), .OUT1VALID(OUT1VALID), .OUT2VALID(OUT2VALID)
  );

  reg_file_8x8 #(.DATA_W(8), .ADDR_W(3), .BYPASS(1'b1)) dut_byp (
    .CLK(CLK), .RESET_N(RESET_N), .IN(IN), .INADDRESS(INADDRESS),
    .WRITE(WRITE), .BUSYWAIT(BUSYWAIT),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(b_out1), .OUT2(b_out2), .OUT1VALID(b_out1_vld), .OUT2VALID(b_out2_vld)
  );

  // Reference model: what each register holds and whether it was written since reset.
  logic [7:0] ref_mem [8];
  logic       ref_vld [8];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = 8'h00;
      ref_vld[i] = 1'b0;
    end
  endtask

  // Advance one rising edge; the model commits using the inputs held across that edge.
  task automatic tick();
    @(posedge CLK);
    if (RESET_N && WRITE && !BUSYWAIT) begin
      ref_mem[INADDRESS] = IN;
      ref_vld[INADDRESS] = 1'b1;
    end
    #1;
  endtask

  // Compare both read ports of both instances against the model for the current inputs.
  task automatic check_ports(input string tag);
    logic       wr_now;
    logic [7:0] e1, e2, be1, be2;
    logic       ev1, ev2, bev1, bev2;
    wr_now = RESET_N && WRITE && !BUSYWAIT;
    e1  = ref_mem[OUT1ADDRESS];
    ev1 = ref_vld[OUT1ADDRESS];
    e2  = ref_mem[OUT2ADDRESS];
    ev2 = ref_vld[OUT2ADDRESS];
    be1 = (wr_now && OUT1ADDRESS == INADDRESS) ? IN : e1;
    bev1 = (wr_now && OUT1ADDRESS == INADDRESS) ? 1'b1 : ev1;
    be2 = (wr_now && OUT2ADDRESS == INADDRESS) ? IN : e2;
    bev2 = (wr_now && OUT2ADDRESS == INADDRESS) ? 1'b1 : ev2;
    chk({tag, ".out1"},      OUT1,                e1);
    chk({tag, ".out2"},      OUT2,                e2);
    chk({tag, ".out1vld"},   {7'd0, OUT1VALID},   {7'd0, ev1});
    chk({tag, ".out2vld"},   {7'd0, OUT2VALID},   {7'd0, ev2});
    chk({tag, ".byp.out1"},  b_out1,              be1);
    chk({tag, ".byp.out2"},  b_out2,              be2);
    chk({tag, ".byp.vld1"},  {7'd0, b_out1_vld},  {7'd0, bev1});
    chk({tag, ".byp.vld2"},  {7'd0, b_out2_vld},  {7'd0, bev2});
  endtask

  // Sweep every address on both ports (port 2 in reverse order); fits between edges.
  task automatic check_all(input string tag);
    for (int i = 0; i < 8; i++) begin
      OUT1ADDRESS = 3'(i);
      OUT2ADDRESS = 3'(7 - i);
      #1;
      check_ports(tag);
    end
  endtask

  initial begin
    RESET_N = 1'b0; IN = 8'h00; INADDRESS = 3'd0; WRITE = 1'b0; BUSYWAIT = 1'b0;
    OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd0;
    model_reset();
    #3;
    check_ports("por");
    @(posedge CLK);
    #5 RESET_N = 1'b1;
    tick();
    check_all("post_por");

    // Reset mid-cycle clears r3 immediately and blocks writes while held.
    WRITE = 1'b1; INADDRESS = 3'd3; IN = 8'h5A;
    tick();
    WRITE = 1'b0; OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd3;
    #1;
    chk("rst.pre.out1", OUT1, 8'h5A);
    #2 RESET_N = 1'b0;
    model_reset();
    #1;
    chk("rst.mid.out1", OUT1, 8'h00);
    chk("rst.mid.vld1", {7'd0, OUT1VALID}, 8'h00);
    check_ports("rst.mid");
    WRITE = 1'b1; IN = 8'h77;
    tick();
    chk("rst.held.out1", OUT1, 8'h00);
    check_ports("rst.held");
    #3 RESET_N = 1'b1;
    WRITE = 1'b0;
    #1;
    check_all("rst.release");
    tick();

    // Write r1 and r6, read them on the two ports, others stay empty.
    WRITE = 1'b1; INADDRESS = 3'd1; IN = 8'h0F;
    tick();
    INADDRESS = 3'd6; IN = 8'hF0;
    tick();
    WRITE = 1'b0; OUT1ADDRESS = 3'd1; OUT2ADDRESS = 3'd6;
    #1;
    chk("wr.out1", OUT1, 8'h0F);
    chk("wr.out2", OUT2, 8'hF0);
    chk("wr.vld1", {7'd0, OUT1VALID}, 8'h01);
    chk("wr.vld2", {7'd0, OUT2VALID}, 8'h01);
    check_all("wr");
    tick();

    // Stall: held write to r2 commits only on the first non-busy edge.
    WRITE = 1'b1; INADDRESS = 3'd2; IN = 8'h33; BUSYWAIT = 1'b1;
    OUT1ADDRESS = 3'd2; OUT2ADDRESS = 3'd2;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall.out1", OUT1, 8'h00);
      chk("stall.vld1", {7'd0, OUT1VALID}, 8'h00);
      check_ports("stall");
    end
    BUSYWAIT = 1'b0;
    #1;
    check_ports("stall.release");
    tick();
    WRITE = 1'b0;
    #1;
    chk("stall.done.out1", OUT1, 8'h33);
    chk("stall.done.vld1", {7'd0, OUT1VALID}, 8'h01);
    tick();

    // Read during write on r4, both ports.
    WRITE = 1'b1; INADDRESS = 3'd4; IN = 8'h11;
    tick();
    IN = 8'h22; OUT1ADDRESS = 3'd4; OUT2ADDRESS = 3'd4;
    #1;
    chk("rdw.pre.out1", OUT1, 8'h11);
    chk("rdw.pre.out2", OUT2, 8'h11);
    chk("rdw.pre.byp1", b_out1, 8'h22);
    chk("rdw.pre.byp2", b_out2, 8'h22);
    check_ports("rdw.pre");
    tick();
    WRITE = 1'b0;
    #1;
    chk("rdw.post.out1", OUT1, 8'h22);
    chk("rdw.post.out2", OUT2, 8'h22);
    tick();

    // Sweep r0..r7 = 0x80+i, then overwrite r7.
    WRITE = 1'b1;
    for (int i = 0; i < 8; i++) begin
      INADDRESS = 3'(i); IN = 8'h80 + 8'(i);
      tick();
    end
    INADDRESS = 3'd7; IN = 8'hFF;
    tick();
    WRITE = 1'b0;
    OUT1ADDRESS = 3'd7; OUT2ADDRESS = 3'd0;
    #1;
    chk("sweep.r7", OUT1, 8'hFF);
    chk("sweep.r0", OUT2, 8'h80);
    check_all("sweep");
    tick();

    // WRITE=0 with changing data/address: nothing moves.
    for (int k = 0; k < 8; k++) begin
      IN = 8'($urandom); INADDRESS = 3'($urandom); BUSYWAIT = 1'($urandom);
      tick();
    end
    OUT1ADDRESS = 3'd5; OUT2ADDRESS = 3'd3;
    #1;
    chk("nowr.r5", OUT1, 8'h85);
    chk("nowr.r3", OUT2, 8'h83);
    check_all("nowr");
    tick();

    // Random traffic with occasional mid-cycle resets.
    for (int k = 0; k < 400; k++) begin
      WRITE = 1'($urandom); BUSYWAIT = ($urandom_range(0, 3) == 0);
      IN = 8'($urandom); INADDRESS = 3'($urandom);
      OUT1ADDRESS = 3'($urandom); OUT2ADDRESS = 3'($urandom);
      #1;
      check_ports("rand");
      if ($urandom_range(0, 49) == 0) begin
        #1 RESET_N = 1'b0;
        model_reset();
        #1;
        check_ports("rand.rst");
        #1 RESET_N = 1'b1;
        #1;
        check_ports("rand.rst.rel");
      end
      tick();
    end
    WRITE = 1'b0;
    #1;
    check_all("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
